regbus_arbiter: RTL and testbench
=================================

Name: regbus_arbiter

Overview:
- Shares the single register-file access port (address map: PPS dividers, pulse generators, channel mux) between two requesters.
- Requester 0 is the SPI command decoder, issuing single-beat reads and writes.
- Requester 1 is the TSIP time-packet decoder, issuing locked multi-beat write bursts so that a full date/time update is never interleaved with SPI accesses.
- Arbitration is round-robin between bursts, and a watchdog releases a requester that stalls mid-burst.

Parameters:
AW, 8, address width
DW, 8, data width
TIMEOUT, 1024, max cycles allowed in WAIT with granted request low (102.4 us at 10 MHz)

Ports:
i_clk  in  1  system clock (10 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_req_0 / i_req_1  in  1  access request; held with addr/data/we/last stable until ack
i_we_0 / i_we_1  in  1  1=write, 0=read
i_last_0 / i_last_1  in  1  final beat of burst; tie high for single beats
i_addr_0 / i_addr_1  in  AW  register address
i_wdata_0 / i_wdata_1  in  DW  write data
o_ack_0 / o_ack_1  out  1  one-cycle pulse, beat complete
o_rdata_0 / o_rdata_1  out  DW  read data, valid with ack, held until next read ack to that requester
o_bus_en  out  1  register access strobe, one cycle per beat
o_bus_we  out  1  write qualifier for o_bus_en
o_bus_addr  out  AW  access address
o_bus_wdata  out  DW  write data
i_bus_rdata  in  DW  combinational read data for o_bus_addr
o_grant  out  2  one-hot current owner, 00 when idle
o_timeout_err  out  1  sticky watchdog flag
i_err_clr  in  1  clears o_timeout_err

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - last_owner=1, so requester 0 wins the first tie.
  - Watchdog counter 0.
- Reset asserted mid-operation: all outputs return to reset values immediately. Any beat not yet acked is dropped; the requester re-requests after reset.
- IDLE:
  - One requester high: grant it.
  - Both high: grant the one not equal to last_owner.
  - Grant registers o_grant and moves to ISSUE next cycle.
- ISSUE (1 cycle):
  - o_bus_en=1; o_bus_we/addr/wdata copy the owner's inputs.
  - For reads, i_bus_rdata is captured at the end of this cycle.
  - Next state: RESP.
- RESP (1 cycle):
  - o_ack_owner=1; o_rdata_owner updated if the beat was a read.
  - last=1: release grant, last_owner<=owner, go to IDLE.
  - last=0: go to WAIT.
- WAIT:
  - Grant held; the other requester is blocked.
  - Owner req high: go to ISSUE and clear the watchdog.
  - Otherwise increment the watchdog.
  - When the watchdog reaches TIMEOUT-1: set o_timeout_err, release grant, last_owner<=owner, go to IDLE.
- Throughput and latency:
  - Single beat: req high in IDLE -> bus strobe 2 cycles later -> ack 3 cycles after req.
  - Burst: subsequent beats every 2 cycles when req stays high.
- o_bus_en is never high outside ISSUE; o_ack_* is never high for a non-owner; exactly one ack per bus strobe.
- A requester dropping req during ISSUE or RESP still receives its ack (the beat is already committed).
- A new request from the owner during RESP with last=1 re-arbitrates in IDLE (no back-to-back grant if the other requester is waiting).
- i_err_clr and timeout in the same cycle: set wins.
- The arbiter does not decode addresses; writes and reads pass through unchanged.

Test Plan:
1. SPI write: req_0, we=1, last=1, addr=0x12, wdata=0x14 -> o_bus_en pulse with 0x12/0x14 two cycles after req; ack_0 the next cycle; o_grant 01 then 00.
2. SPI read: req_0 read, addr=0x13 with i_bus_rdata=0x08 -> ack_0 with o_rdata_0=0x08, held after ack.
3. TSIP burst: 7 writes to addrs 0x40..0x46 (sec=29, min=16, hour=16, day=15, month=7, year 0x08/0x10) with req_0 asserted after beat 2 -> all 7 strobes are consecutive TSIP beats; SPI is granted only after the last ack.
4. Simultaneous req_0 and req_1 from reset -> requester 0 served first, then 1; repeat both -> requester 0 wins again only after 1 has been served (alternation).
5. Stalled burst: req_1 drops after beat 3 with last=0 -> after 1024 idle WAIT cycles o_timeout_err=1 and grant released; pending req_0 is granted next; i_err_clr clears the flag; clear coinciding with a new timeout leaves it set.
6. Reset pulse during WAIT of a burst -> outputs 0 immediately; after release, arbitration restarts with requester 0 preferred.

Source files
------------

// File: rtl/regbus_arbiter.sv
// Two-requester arbiter for the shared register-file port: round-robin between
// bursts, locked multi-beat bursts, and a watchdog that frees a stalled owner.
module regbus_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_0,
  input  logic          i_req_1,
  input  logic          i_we_0,
  input  logic          i_we_1,
  input  logic          i_last_0,
  input  logic          i_last_1,
  input  logic [AW-1:0] i_addr_0,
  input  logic [AW-1:0] i_addr_1,
  input  logic [DW-1:0] i_wdata_0,
  input  logic [DW-1:0] i_wdata_1,
  output logic          o_ack_0,
  output logic          o_ack_1,
  output logic [DW-1:0] o_rdata_0,
  output logic [DW-1:0] o_rdata_1,
  output logic          o_bus_en,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  input  logic [DW-1:0] i_bus_rdata,
  output logic [1:0]    o_grant,
  output logic          o_timeout_err,
  input  logic          i_err_clr
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic [1:0]      grant_q, grant_d;
  logic            bus_en_q, bus_en_d;
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            beat_last_q, beat_last_d;
  logic            ack_0_q, ack_0_d;
  logic            ack_1_q, ack_1_d;
  logic [DW-1:0]   rdata_0_q, rdata_0_d;
  logic [DW-1:0]   rdata_1_q, rdata_1_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;

  logic            own_req, own_we, own_last;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;
  logic            launch;
  logic            pick;

  always_comb begin
    if (owner_q) begin
      own_req   = i_req_1;
      own_we    = i_we_1;
      own_last  = i_last_1;
      own_addr  = i_addr_1;
      own_wdata = i_wdata_1;
    end else begin
      own_req   = i_req_0;
      own_we    = i_we_0;
      own_last  = i_last_0;
      own_addr  = i_addr_0;
      own_wdata = i_wdata_0;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    bus_en_d     = 1'b0;
    bus_we_d     = 1'b0;
    bus_addr_d   = '0;
    bus_wdata_d  = '0;
    beat_last_d  = beat_last_q;
    ack_0_d      = 1'b0;
    ack_1_d      = 1'b0;
    rdata_0_d    = rdata_0_q;
    rdata_1_d    = rdata_1_q;
    wd_d         = wd_q;
    err_d        = err_q & ~i_err_clr;
    launch       = 1'b0;
    pick         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_req_0 || i_req_1) begin
          pick    = (i_req_0 && i_req_1) ? ~last_owner_q : i_req_1;
          owner_d = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        launch  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        ack_0_d = ~owner_q;
        ack_1_d = owner_q;
        if (!bus_we_q) begin
          if (owner_q) rdata_1_d = i_bus_rdata;
          else         rdata_0_d = i_bus_rdata;
        end
        if (beat_last_q) begin
          grant_d      = '0;
          last_owner_d = owner_q;
          state_d      = S_IDLE;
        end else begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The next beat's strobe is registered straight from WAIT so a burst
        // sustains one beat every two cycles.
        if (own_req) begin
          launch  = 1'b1;
          wd_d    = '0;
          state_d = S_RESP;
        end else if (wd_q == WD_LAST) begin
          err_d        = 1'b1;
          grant_d      = '0;
          last_owner_d = owner_q;
          wd_d         = '0;
          state_d      = S_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      bus_en_d    = 1'b1;
      bus_we_d    = own_we;
      bus_addr_d  = own_addr;
      bus_wdata_d = own_wdata;
      beat_last_d = own_last;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      grant_q      <= '0;
      bus_en_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      beat_last_q  <= 1'b0;
      ack_0_q      <= 1'b0;
      ack_1_q      <= 1'b0;
      rdata_0_q    <= '0;
      rdata_1_q    <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      bus_en_q     <= bus_en_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      beat_last_q  <= beat_last_d;
      ack_0_q      <= ack_0_d;
      ack_1_q      <= ack_1_d;
      rdata_0_q    <= rdata_0_d;
      rdata_1_q    <= rdata_1_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
    end
  end

  assign o_ack_0       = ack_0_q;
  assign o_ack_1       = ack_1_q;
  assign o_rdata_0     = rdata_0_q;
  assign o_rdata_1     = rdata_1_q;
  assign o_bus_en      = bus_en_q;
  assign o_bus_we      = bus_we_q;
  assign o_bus_addr    = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_grant       = grant_q;
  assign o_timeout_err = err_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter: single beats, locked bursts, alternation,
// watchdog release and asynchronous reset.
module tb_regbus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_0, req_1, we_0, we_1, last_0, last_1;
  logic [7:0] addr_0, addr_1, wdata_0, wdata_1;
  logic [7:0] bus_rdata;
  logic       err_clr;
  logic       ack_0, ack_1, bus_en, bus_we, timeout_err;
  logic [7:0] rdata_0, rdata_1, bus_addr, bus_wdata;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regbus_arbiter #(.AW(8), .DW(8), .TIMEOUT(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_0(req_0), .i_req_1(req_1),
    .i_we_0(we_0), .i_we_1(we_1),
    .i_last_0(last_0), .i_last_1(last_1),
    .i_addr_0(addr_0), .i_addr_1(addr_1),
    .i_wdata_0(wdata_0), .i_wdata_1(wdata_1),
    .o_ack_0(ack_0), .o_ack_1(ack_1),
    .o_rdata_0(rdata_0), .o_rdata_1(rdata_1),
    .o_bus_en(bus_en), .o_bus_we(bus_we),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata),
    .o_grant(grant), .o_timeout_err(timeout_err),
    .i_err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
    last_0 = 1'b0; last_1 = 1'b0; addr_0 = '0; addr_1 = '0;
    wdata_0 = '0; wdata_1 = '0; bus_rdata = '0; err_clr = 1'b0;
    #12;
    checks++; if ({ack_0, ack_1, rdata_0, rdata_1, bus_en, bus_we, bus_addr, bus_wdata, grant, timeout_err} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {ack_0, ack_1, rdata_0, rdata_1, bus_en, bus_we, bus_addr, bus_wdata, grant, timeout_err});
    end
    step(); rst_n = 1'b1;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_idle_grant got=%b exp=00", grant); end
  endtask

  task automatic test_spi_write();
    req_0 = 1'b1; we_0 = 1'b1; last_0 = 1'b1; addr_0 = 8'h12; wdata_0 = 8'h14;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wr_grant got=%b exp=01", grant); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL wr_early_en got=%b exp=0", bus_en); end
    step();
    checks++; if ({bus_en, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 8'h12, 8'h14}) begin
      errors++; $display("FAIL wr_strobe got=%b/%b/%h/%h exp=1/1/12/14", bus_en, bus_we, bus_addr, bus_wdata);
    end
    checks++; if (ack_0 !== 1'b0) begin errors++; $display("FAIL wr_early_ack got=%b exp=0", ack_0); end
    step();
    checks++; if ({ack_0, ack_1, bus_en} !== 3'b100) begin errors++; $display("FAIL wr_ack got=%b exp=100", {ack_0, ack_1, bus_en}); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_release got=%b exp=00", grant); end
    req_0 = 1'b0;
    step();
    checks++; if (ack_0 !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got=%b exp=0", ack_0); end
  endtask

  task automatic test_spi_read();
    bus_rdata = 8'h08;
    req_0 = 1'b1; we_0 = 1'b0; last_0 = 1'b1; addr_0 = 8'h13;
    step();
    step();
    checks++; if ({bus_en, bus_we, bus_addr} !== {1'b1, 1'b0, 8'h13}) begin
      errors++; $display("FAIL rd_strobe got=%b/%b/%h exp=1/0/13", bus_en, bus_we, bus_addr);
    end
    step();
    checks++; if (ack_0 !== 1'b1 || rdata_0 !== 8'h08) begin
      errors++; $display("FAIL rd_ack got=%b/%h exp=1/08", ack_0, rdata_0);
    end
    req_0 = 1'b0; bus_rdata = 8'h55;
    step(); step();
    checks++; if (rdata_0 !== 8'h08 || rdata_1 !== 8'h00) begin
      errors++; $display("FAIL rd_hold got=%h/%h exp=08/00", rdata_0, rdata_1);
    end
  endtask

  task automatic test_tsip_burst();
    logic [7:0] ts [0:6];
    ts = '{8'd29, 8'd16, 8'd16, 8'd15, 8'd7, 8'h08, 8'h10};
    req_1 = 1'b1; we_1 = 1'b1; last_1 = 1'b0; addr_1 = 8'h40; wdata_1 = ts[0];
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_grant got=%b exp=10", grant); end
    for (int b = 0; b < 7; b++) begin
      step();
      checks++; if ({bus_en, bus_addr, bus_wdata, grant} !== {1'b1, 8'h40 + 8'(b), ts[b], 2'b10}) begin
        errors++; $display("FAIL burst_strobe%0d got=%b/%h/%h/%b exp=1/%h/%h/10", b, bus_en, bus_addr, bus_wdata, grant, 8'h40 + 8'(b), ts[b]);
      end
      step();
      checks++; if ({ack_1, ack_0, bus_en} !== 3'b100) begin
        errors++; $display("FAIL burst_ack%0d got=%b exp=100", b, {ack_1, ack_0, bus_en});
      end
      if (b == 1) begin
        req_0 = 1'b1; we_0 = 1'b1; last_0 = 1'b1; addr_0 = 8'h20; wdata_0 = 8'h21;
      end
      if (b < 6) begin
        addr_1 = 8'h41 + 8'(b); wdata_1 = ts[b + 1]; last_1 = (b == 5);
      end else begin
        req_1 = 1'b0;
      end
    end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_release got=%b exp=00", grant); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_spi_grant got=%b exp=01", grant); end
    step();
    checks++; if ({bus_en, bus_addr, bus_wdata} !== {1'b1, 8'h20, 8'h21}) begin
      errors++; $display("FAIL burst_spi_strobe got=%b/%h/%h exp=1/20/21", bus_en, bus_addr, bus_wdata);
    end
    step();
    checks++; if (ack_0 !== 1'b1) begin errors++; $display("FAIL burst_spi_ack got=%b exp=1", ack_0); end
    req_0 = 1'b0;
    step();
  endtask

  task automatic test_alternation();
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req_0 = 1'b1; we_0 = 1'b1; last_0 = 1'b1; addr_0 = 8'h01; wdata_0 = 8'hA0;
    req_1 = 1'b1; we_1 = 1'b1; last_1 = 1'b1; addr_1 = 8'h02; wdata_1 = 8'hB0;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL alt_first got=%b exp=01", grant); end
    step();
    checks++; if (bus_addr !== 8'h01) begin errors++; $display("FAIL alt_first_addr got=%h exp=01", bus_addr); end
    step();
    checks++; if (ack_0 !== 1'b1) begin errors++; $display("FAIL alt_first_ack got=%b exp=1", ack_0); end
    addr_0 = 8'h03; wdata_0 = 8'hA1;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL alt_second got=%b exp=10", grant); end
    step();
    checks++; if ({bus_addr, bus_wdata} !== {8'h02, 8'hB0}) begin
      errors++; $display("FAIL alt_second_bus got=%h/%h exp=02/B0", bus_addr, bus_wdata);
    end
    step();
    checks++; if ({ack_1, ack_0} !== 2'b10) begin errors++; $display("FAIL alt_second_ack got=%b exp=10", {ack_1, ack_0}); end
    req_1 = 1'b0;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL alt_third got=%b exp=01", grant); end
    step();
    checks++; if ({bus_addr, bus_wdata} !== {8'h03, 8'hA1}) begin
      errors++; $display("FAIL alt_third_bus got=%h/%h exp=03/A1", bus_addr, bus_wdata);
    end
    step();
    checks++; if (ack_0 !== 1'b1) begin errors++; $display("FAIL alt_third_ack got=%b exp=1", ack_0); end
    req_0 = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int bad;
    req_1 = 1'b1; we_1 = 1'b1; last_1 = 1'b0; addr_1 = 8'h50; wdata_1 = 8'hC0;
    step();
    for (int b = 0; b < 3; b++) begin
      step();
      checks++; if ({bus_en, bus_addr} !== {1'b1, 8'h50 + 8'(b)}) begin
        errors++; $display("FAIL to_strobe%0d got=%b/%h exp=1/%h", b, bus_en, bus_addr, 8'h50 + 8'(b));
      end
      step();
      addr_1 = 8'h51 + 8'(b); wdata_1 = 8'hC1 + 8'(b);
    end
    req_1 = 1'b0;
    req_0 = 1'b1; we_0 = 1'b1; last_0 = 1'b1; addr_0 = 8'h30; wdata_0 = 8'h33;
    bad = 0;
    for (int k = 0; k < 1023; k++) begin
      step();
      if (grant !== 2'b10 || bus_en !== 1'b0 || ack_0 !== 1'b0 || timeout_err !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_hold_window got=%0d bad cycles exp=0", bad); end
    step();
    checks++; if ({timeout_err, grant} !== 3'b100) begin
      errors++; $display("FAIL to_fire got=%b/%b exp=1/00", timeout_err, grant);
    end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL to_next_grant got=%b exp=01", grant); end
    step();
    checks++; if ({bus_en, bus_addr} !== {1'b1, 8'h30}) begin
      errors++; $display("FAIL to_next_strobe got=%b/%h exp=1/30", bus_en, bus_addr);
    end
    step();
    req_0 = 1'b0;
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
    req_1 = 1'b1; last_1 = 1'b0; addr_1 = 8'h58;
    step(); step(); step();
    req_1 = 1'b0;
    for (int k = 0; k < 1023; k++) step();
    checks++; if ({timeout_err, grant} !== 3'b010) begin
      errors++; $display("FAIL to_pre_fire got=%b/%b exp=0/10", timeout_err, grant);
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    checks++; if ({timeout_err, grant} !== 3'b100) begin
      errors++; $display("FAIL to_set_wins got=%b/%b exp=1/00", timeout_err, grant);
    end
  endtask

  task automatic test_reset_mid_burst();
    bus_rdata = 8'h08;
    req_0 = 1'b1; we_0 = 1'b0; last_0 = 1'b1; addr_0 = 8'h13;
    step(); step(); step();
    req_0 = 1'b0;
    req_1 = 1'b1; we_1 = 1'b1; last_1 = 1'b0; addr_1 = 8'h60; wdata_1 = 8'hD0;
    step(); step(); step(); step();
    req_1 = 1'b0;
    req_0 = 1'b1; we_0 = 1'b1; last_0 = 1'b1; addr_0 = 8'h70; wdata_0 = 8'h77;
    step();
    checks++; if ({grant, rdata_0, timeout_err} !== {2'b10, 8'h08, 1'b1}) begin
      errors++; $display("FAIL mr_pre got=%b/%h/%b exp=10/08/1", grant, rdata_0, timeout_err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ack_0, ack_1, rdata_0, rdata_1, bus_en, bus_we, bus_addr, bus_wdata, grant, timeout_err} !== 39'd0) begin
      errors++; $display("FAIL mr_outputs got=%h exp=0", {ack_0, ack_1, rdata_0, rdata_1, bus_en, bus_we, bus_addr, bus_wdata, grant, timeout_err});
    end
    req_1 = 1'b1; last_1 = 1'b1; addr_1 = 8'h61; wdata_1 = 8'hD1;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mr_held got=%b exp=00", grant); end
    rst_n = 1'b1;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL mr_pref0 got=%b exp=01", grant); end
    step();
    checks++; if ({bus_addr, bus_wdata} !== {8'h70, 8'h77}) begin
      errors++; $display("FAIL mr_strobe0 got=%h/%h exp=70/77", bus_addr, bus_wdata);
    end
    step();
    req_0 = 1'b0;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL mr_grant1 got=%b exp=10", grant); end
    step();
    checks++; if ({bus_en, bus_addr, bus_wdata} !== {1'b1, 8'h61, 8'hD1}) begin
      errors++; $display("FAIL mr_strobe1 got=%b/%h/%h exp=1/61/D1", bus_en, bus_addr, bus_wdata);
    end
    step();
    checks++; if (ack_1 !== 1'b1) begin errors++; $display("FAIL mr_ack1 got=%b exp=1", ack_1); end
    req_1 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_spi_write();
    test_spi_read();
    test_tsip_burst();
    test_alternation();
    test_timeout();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
